// File: rtl/vga_frame_capture.sv
// vga_frame_capture
//   Sinks an 8-bit-colour VGA stream (one pixel every PIX_DIV clocks), locks
//   onto hsync/vsync timing and captures a W x H window row-major into a
//   BRAM write port using the display path's {blue, green, red} byte packing.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-low reset
//   red      in   [2:0] pixel red
//   green    in   [2:0] pixel green
//   blue     in   [1:0] pixel blue
//   hsync    in   horizontal sync, active-low pulse
//   vsync    in   vertical sync, active-low pulse
//   start    in   one-cycle capture request
//   busy     out  high from start acceptance until done
//   done     out  one-cycle pulse after the last window pixel is written
//   err      out  sticky error; cleared by reset or the next accepted start
//   wr_en    out  BRAM write strobe
//   wr_addr  out  [ADDR_BITS-1:0] BRAM write address
//   wr_data  out  [7:0] {blue[1:0], green[2:0], red[2:0]}
//
// Optional feature (macro SYNC_CHECK_EN): measure the hfall-to-hfall period
// and abort an armed/running capture on any line that is not exactly
// HPIXELS*PIX_DIV clocks long.

module vga_frame_capture #(
    parameter int unsigned PIX_DIV   = 4,
    parameter int unsigned HPIXELS   = 800,
    parameter int unsigned VLINES    = 521,
    parameter int unsigned HBP       = 144,
    parameter int unsigned VBP       = 31,
    parameter int unsigned X0        = 50,
    parameter int unsigned Y0        = 100,
    parameter int unsigned W         = 256,
    parameter int unsigned H         = 256,
    parameter int unsigned ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           red,
    input  logic [2:0]           green,
    input  logic [1:0]           blue,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_data
);

    localparam int unsigned PHW    = $clog2(PIX_DIV);
    localparam int unsigned HW     = $clog2(HPIXELS);
    localparam int unsigned VW     = $clog2(VLINES + 1);
    localparam int unsigned COL_LO = HBP + X0;
    localparam int unsigned COL_HI = HBP + X0 + W;
    localparam int unsigned ROW_LO = VBP + Y0;
    localparam int unsigned ROW_HI = VBP + Y0 + H;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(W * H - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        CAPTURE,
        DONE
    } state_t;

    state_t state;

    // Input stage: one register for colour and syncs, a second for edge detect.
    logic [7:0] pix1;
    logic       hs1, vs1, hs2, vs2;
    logic       hfall, vfall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pix1 <= '0;
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            hs2  <= 1'b0;
            vs2  <= 1'b0;
        end else begin
            pix1 <= {blue, green, red};
            hs1  <= hsync;
            vs1  <= vsync;
            hs2  <= hs1;
            vs2  <= vs1;
        end
    end

    assign hfall = hs2 & ~hs1;
    assign vfall = vs2 & ~vs1;

    // Pixel phase and horizontal/vertical position, re-aligned on each sync edge.
    logic [PHW-1:0] phase;
    logic [HW-1:0]  hcnt;
    logic [VW-1:0]  vcnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= '0;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            if (hfall) begin
                phase <= PHW'(1);
                hcnt  <= '0;
            end else if (phase == PHW'(PIX_DIV - 1)) begin
                phase <= '0;
                if (32'(hcnt) < HPIXELS - 1) begin
                    hcnt <= hcnt + 1'b1;
                end
            end else begin
                phase <= phase + 1'b1;
            end

            if (vfall) begin
                vcnt <= '0;
            end else if (hfall && (32'(vcnt) < VLINES)) begin
                vcnt <= vcnt + 1'b1;
            end
        end
    end

    logic in_win;
    logic sample_hit;
    logic at_vlimit;

    assign in_win     = (32'(hcnt) >= COL_LO) && (32'(hcnt) < COL_HI) &&
                        (32'(vcnt) >= ROW_LO) && (32'(vcnt) < ROW_HI);
    assign sample_hit = (phase == PHW'(PIX_DIV / 2)) && in_win;
    // vcnt only reaches VLINES when a whole frame passed without a vsync edge.
    assign at_vlimit  = (32'(vcnt) == VLINES);

    logic per_err;

`ifdef SYNC_CHECK_EN
    localparam int unsigned LINE_CLKS = HPIXELS * PIX_DIV;
    localparam int unsigned PW        = $clog2(2 * LINE_CLKS + 1);

    logic [PW-1:0] per_cnt;
    logic          per_valid;

    // per_cnt holds the clocks since the previous hfall, counting that cycle as 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            per_cnt   <= '0;
            per_valid <= 1'b0;
        end else begin
            if (hfall) begin
                per_cnt <= PW'(1);
            end else if (per_cnt != {PW{1'b1}}) begin
                per_cnt <= per_cnt + 1'b1;
            end

            // The first hfall after arming only opens the measurement window.
            if (state == IDLE) begin
                per_valid <= 1'b0;
            end else if (hfall) begin
                per_valid <= 1'b1;
            end
        end
    end

    assign per_err = hfall && per_valid &&
                     ((state == ARM) || (state == CAPTURE)) &&
                     (32'(per_cnt) != LINE_CLKS);
`else
    assign per_err = 1'b0;
`endif

    // Capture control; all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            done  <= 1'b0;
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        wr_addr <= '0;
                        // A vsync edge in the acceptance cycle starts this frame.
                        state   <= vfall ? CAPTURE : ARM;
                    end
                end
                ARM: begin
                    if (vfall) begin
                        state <= CAPTURE;
                    end else if (at_vlimit || per_err) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CAPTURE: begin
                    if (wr_en && (wr_addr == LAST_ADDR)) begin
                        // Last write is on the bus this cycle; address is held.
                        state <= DONE;
                    end else if (vfall || at_vlimit || per_err) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (wr_en) begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                        if (sample_hit) begin
                            wr_en   <= 1'b1;
                            wr_data <= pix1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture
//   Directed bench for vga_frame_capture on a reduced frame (32 x 24 pixels,
//   PIX_DIV = 4, 8 x 8 window) so that each scenario spans only a few frames.
//   A free-running generator produces the VGA stream with pixel byte
//   ((hc*5) ^ (vc*16)) & 8'hFF; a monitor logs every write and done pulse.

module tb_vga_frame_capture;

    localparam int unsigned PIX_DIV = 4;
    localparam int unsigned HPIX    = 32;
    localparam int unsigned VLIN    = 24;
    localparam int unsigned HBP     = 6;
    localparam int unsigned VBP     = 3;
    localparam int unsigned X0      = 2;
    localparam int unsigned Y0      = 2;
    localparam int unsigned W       = 8;
    localparam int unsigned H       = 8;
    localparam int unsigned AB      = 6;
    localparam int NPIX       = W * H;
    localparam int FRAME_CLKS = HPIX * VLIN * PIX_DIV;
    localparam int HSW        = 4;
    localparam int VSW        = 2;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic [2:0]    red    = '0;
    logic [2:0]    green  = '0;
    logic [1:0]    blue   = '0;
    logic          hsync  = 1'b1;
    logic          vsync  = 1'b1;
    logic          start  = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [7:0]    wr_data;

    int total = 0;
    int bad   = 0;

    // Generator position and controls set by the tests.
    int gl = 0;
    int gp = 0;
    int frame_no = 0;
    int start_line = -1;
    int stretch_line = -1;
    bit vs_en = 1'b1;

    logic [AB-1:0] q_addr[$];
    logic [7:0]    q_data[$];
    int            q_frame[$];
    int            done_cnt = 0;

    vga_frame_capture #(
        .PIX_DIV  (PIX_DIV),
        .HPIXELS  (HPIX),
        .VLINES   (VLIN),
        .HBP      (HBP),
        .VBP      (VBP),
        .X0       (X0),
        .Y0       (Y0),
        .W        (W),
        .H        (H),
        .ADDR_BITS(AB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .red    (red),
        .green  (green),
        .blue   (blue),
        .hsync  (hsync),
        .vsync  (vsync),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_byte(input int hc, input int vc);
        int v;
        v = (hc * 5) ^ (vc * 16);
        return 8'(v);
    endfunction

    // VGA source: pixel values change on a negedge and hold PIX_DIV clocks.
    initial begin : gen
        @(negedge clk);
        forever begin
            for (int l = 0; l < VLIN; l++) begin
                int npix;
                npix = (l == stretch_line) ? HPIX + 1 : HPIX;
                for (int p = 0; p < npix; p++) begin
                    logic [7:0] b;
                    gl = l;
                    gp = p;
                    if (l == 0 && p == 0) frame_no++;
                    b     = pix_byte(p, l);
                    red   = b[2:0];
                    green = b[5:3];
                    blue  = b[7:6];
                    hsync = (p >= HSW);
                    vsync = vs_en ? (l >= VSW) : 1'b1;
                    for (int c = 0; c < PIX_DIV; c++) begin
                        start = (c == 1) && (p == 0) && (l == start_line);
                        @(negedge clk);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (wr_en) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
            q_frame.push_back(frame_no);
        end
        if (done) done_cnt++;
    end

    task automatic wait_busy(input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (err !== 1'b0)     begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (wr_en !== 1'b0)   begin bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        total++; if (wr_addr !== '0)   begin bad++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    endtask

    task automatic test_capture();
        int base, dbase, sf;
        bit ok;
        base = q_addr.size();
        dbase = done_cnt;
        start_line = 20;
        wait_busy(1'b1, 2 * FRAME_CLKS, ok);
        start_line = -1;
        sf = frame_no;
        total++; if (!ok) begin bad++; $display("FAIL cap_busy_rise: busy=%b want 1", busy); end
        wait_busy(1'b0, 3 * FRAME_CLKS, ok);
        total++; if (!ok) begin bad++; $display("FAIL cap_busy_fall: busy=%b want 0", busy); end
        repeat (4) @(negedge clk);
        total++; if (q_addr.size() - base != NPIX) begin bad++; $display("FAIL cap_count: got %0d want %0d", q_addr.size() - base, NPIX); end
        total++; if (done_cnt - dbase != 1) begin bad++; $display("FAIL cap_done: got %0d pulses want 1", done_cnt - dbase); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL cap_err: got %b want 0", err); end
        if (q_addr.size() - base == NPIX) begin
            total++; if (q_frame[base] != sf + 1) begin bad++; $display("FAIL cap_first_frame: got %0d want %0d", q_frame[base], sf + 1); end
            for (int i = 0; i < NPIX; i++) begin
                logic [7:0] want;
                want = pix_byte(HBP + X0 + i % W, VBP + Y0 + i / W);
                total++;
                if (q_addr[base + i] !== AB'(i) || q_data[base + i] !== want) begin
                    bad++;
                    $display("FAIL cap_px%0d: addr=%0d data=%h want addr=%0d data=%h",
                             i, q_addr[base + i], q_data[base + i], i, want);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int base, dbase;
        bit ok;
        base = q_addr.size();
        dbase = done_cnt;
        start_line = 20;
        wait_busy(1'b1, 2 * FRAME_CLKS, ok);
        start_line = -1;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (q_addr.size() > base) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL busy_first_write: writes=%0d want >0", q_addr.size() - base); end
        // Second request lands on a window line, mid capture.
        start_line = VBP + Y0 + 2;
        wait_busy(1'b0, 2 * FRAME_CLKS, ok);
        start_line = -1;
        repeat (4) @(negedge clk);
        total++; if (q_addr.size() - base != NPIX) begin bad++; $display("FAIL busy_count: got %0d want %0d", q_addr.size() - base, NPIX); end
        total++; if (done_cnt - dbase != 1) begin bad++; $display("FAIL busy_done: got %0d pulses want 1", done_cnt - dbase); end
        total++; if (wr_addr !== AB'(NPIX - 1)) begin bad++; $display("FAIL busy_last_addr: got %0d want %0d", wr_addr, NPIX - 1); end
    endtask

    task automatic test_vfall_start();
        int base, dbase, sf;
        bit ok;
        base = q_addr.size();
        dbase = done_cnt;
        start_line = 0;
        wait_busy(1'b1, 2 * FRAME_CLKS, ok);
        start_line = -1;
        sf = frame_no;
        wait_busy(1'b0, 2 * FRAME_CLKS, ok);
        repeat (4) @(negedge clk);
        total++; if (q_addr.size() - base != NPIX) begin bad++; $display("FAIL vfs_count: got %0d want %0d", q_addr.size() - base, NPIX); end
        total++; if (done_cnt - dbase != 1) begin bad++; $display("FAIL vfs_done: got %0d pulses want 1", done_cnt - dbase); end
        if (q_addr.size() > base) begin
            total++; if (q_frame[base] != sf) begin bad++; $display("FAIL vfs_same_frame: got %0d want %0d", q_frame[base], sf); end
            total++; if (q_data[base] !== pix_byte(HBP + X0, VBP + Y0)) begin bad++; $display("FAIL vfs_first_data: got %h want %h", q_data[base], pix_byte(HBP + X0, VBP + Y0)); end
        end
    endtask

    task automatic test_reset_mid();
        int base, dbase, n;
        bit ok;
        base = q_addr.size();
        dbase = done_cnt;
        start_line = 20;
        wait_busy(1'b1, 2 * FRAME_CLKS, ok);
        start_line = -1;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (q_addr.size() >= base + 20) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL rst_mid_reach: writes=%0d want 20", q_addr.size() - base); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_mid_wr_en: got %b want 0", wr_en); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n = q_addr.size();
        repeat (2 * FRAME_CLKS) @(negedge clk);
        total++; if (q_addr.size() != n) begin bad++; $display("FAIL rst_mid_writes: got %0d extra want 0", q_addr.size() - n); end
        total++; if (done_cnt != dbase) begin bad++; $display("FAIL rst_mid_done: got %0d pulses want 0", done_cnt - dbase); end
    endtask

    task automatic test_no_vsync();
        int base, dbase, sf;
        bit ok;
        base = q_addr.size();
        dbase = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            @(negedge clk);
            if (gl == VSW) begin
                ok = 1'b1;
                break;
            end
        end
        vs_en = 1'b0;
        start_line = 20;
        wait_busy(1'b1, 2 * FRAME_CLKS, ok);
        start_line = -1;
        sf = frame_no;
        total++; if (!ok) begin bad++; $display("FAIL nvs_busy_rise: busy=%b want 1", busy); end
        wait_busy(1'b0, 2 * FRAME_CLKS, ok);
        // vcnt hits VLINES at the first line of the following frame.
        total++; if (gl != 0 || frame_no != sf + 1) begin bad++; $display("FAIL nvs_when: line=%0d frame=%0d want line=0 frame=%0d", gl, frame_no, sf + 1); end
        vs_en = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (err !== 1'b1)  begin bad++; $display("FAIL nvs_err: got %b want 1", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nvs_busy: got %b want 0", busy); end
        total++; if (q_addr.size() != base) begin bad++; $display("FAIL nvs_writes: got %0d want 0", q_addr.size() - base); end
        total++; if (done_cnt != dbase) begin bad++; $display("FAIL nvs_done: got %0d pulses want 0", done_cnt - dbase); end
    endtask

    task automatic test_line_stretch();
        int base, dbase;
        bit ok;
        base = q_addr.size();
        dbase = done_cnt;
        stretch_line = VBP + Y0 + 1;
        start_line = 20;
        wait_busy(1'b1, 2 * FRAME_CLKS, ok);
        start_line = -1;
        repeat (2) @(negedge clk);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL str_err_clear: got %b want 0", err); end
        wait_busy(1'b0, 3 * FRAME_CLKS, ok);
        stretch_line = -1;
        repeat (4) @(negedge clk);
`ifdef SYNC_CHECK_EN
        total++; if (err !== 1'b1) begin bad++; $display("FAIL str_err: got %b want 1", err); end
        total++; if (q_addr.size() - base != 2 * W) begin bad++; $display("FAIL str_count: got %0d want %0d", q_addr.size() - base, 2 * W); end
        total++; if (done_cnt != dbase) begin bad++; $display("FAIL str_done: got %0d pulses want 0", done_cnt - dbase); end
`else
        total++; if (err !== 1'b0) begin bad++; $display("FAIL str_err: got %b want 0", err); end
        total++; if (q_addr.size() - base != NPIX) begin bad++; $display("FAIL str_count: got %0d want %0d", q_addr.size() - base, NPIX); end
        total++; if (done_cnt - dbase != 1) begin bad++; $display("FAIL str_done: got %0d pulses want 1", done_cnt - dbase); end
`endif
    endtask

    initial begin
        test_reset();
        test_capture();
        test_start_while_busy();
        test_vfall_start();
        test_reset_mid();
        test_no_vsync();
        test_line_stretch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
